vga_fb_reader: RTL and testbench

//  Pixel source directly upstream of the vga timing/output stage. Holds a 160x120 RGB332

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_fb_ram.sv | 30 +++
 rtl/vga_fb_reader.sv | 156 +++++++++++++++
 tb/tb_vga_fb_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and payload types for the framebuffer reader.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned CNT_W      = 10;
  localparam int unsigned FB_W       = 160;
  localparam int unsigned FB_H       = 120;
  localparam int unsigned SCALE_LOG2 = 2;
  localparam int unsigned FB_ADDR_W  = 15;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Row-major offset for a 160-wide framebuffer: y*160 + x as two shifts and adds
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return (FB_ADDR_W'(y) << 7) + (FB_ADDR_W'(y) << 5) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port whose output
// register clears when the read is disabled (blanking / reset).
module vga_fb_ram #(
  parameter int unsigned DEPTH  = 19200,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Read-before-write: a same-edge read of the written address returns the old word
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= i_rd_en ? r_mem[i_rd_addr] : '0;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vga_fb_reader.sv
// 160x120 RGB332 framebuffer scaled 4x to 640x480, read one pixel ahead of the VGA stage.
// Define VGA_FB_DOUBLE_BUFFER_EN for two banks with a vblank-synchronised swap.
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int unsigned FB_W       = vga_pkg::FB_W,
  parameter int unsigned FB_H       = vga_pkg::FB_H,
  parameter int unsigned SCALE_LOG2 = vga_pkg::SCALE_LOG2
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic [9:0]       hc_in,
  input  logic [9:0]       vc_in,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_x,
  input  logic [6:0]       wr_y,
  input  logic [7:0]       wr_data,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             front_bank,
  output logic             vblank_start,
  output logic [2:0]       pix_red,
  output logic [2:0]       pix_green,
  output logic [1:0]       pix_blue
);

  localparam int unsigned BANK_SIZE = FB_W * FB_H;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
  localparam int unsigned RAM_DEPTH = 2 * BANK_SIZE;
`else
  localparam int unsigned RAM_DEPTH = BANK_SIZE;
`endif
  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

  logic [CNT_W-1:0]     w_nh;
  logic [CNT_W-1:0]     w_nv;
  logic                 w_last_h;
  logic                 w_active;
  logic                 w_vb_cond;
  logic                 w_in_range;
  logic                 w_we;
  logic [FB_ADDR_W-1:0] w_rd_off;
  logic [FB_ADDR_W-1:0] w_wr_off;
  logic [RAM_AW-1:0]    w_rd_addr;
  logic [RAM_AW-1:0]    w_wr_addr;
  rgb332_t              w_pix;
  logic                 r_wr_ready;
  logic                 r_vblank;

  // Position the VGA stage will show on the next cycle
  always_comb begin
    w_last_h = (hc_in == CNT_W'(H_TOTAL - 1));
    w_nh     = w_last_h ? '0 : hc_in + CNT_W'(1);
    w_nv     = vc_in;
    if (w_last_h) begin
      w_nv = (vc_in == CNT_W'(V_TOTAL - 1)) ? '0 : vc_in + CNT_W'(1);
    end
  end

  assign w_active   = (w_nh < CNT_W'(H_ACTIVE)) && (w_nv < CNT_W'(V_ACTIVE));
  assign w_vb_cond  = (hc_in == '0) && (vc_in == CNT_W'(V_ACTIVE));
  assign w_rd_off   = fb_addr(8'(w_nh >> SCALE_LOG2), 7'(w_nv >> SCALE_LOG2));
  assign w_wr_off   = fb_addr(wr_x, wr_y);
  assign w_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
  assign w_we       = wr_valid && r_wr_ready && !rst && w_in_range;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_wr_ready <= 1'b0;
      r_vblank   <= 1'b0;
    end else begin
      r_wr_ready <= 1'b1;
      r_vblank   <= w_vb_cond;
    end
  end

`ifdef VGA_FB_DOUBLE_BUFFER_EN
  swap_state_t r_state;
  swap_state_t w_state_nxt;
  logic        w_swap;
  logic        r_front_bank;
  logic        r_swap_ack;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_state      <= SWAP_IDLE;
      r_front_bank <= 1'b0;
      r_swap_ack   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_front_bank <= r_front_bank ^ w_swap;
      r_swap_ack   <= w_swap;
    end
  end

  // A request landing on the vblank edge swaps at once; later requests while pending merge
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      SWAP_IDLE: begin
        if (swap_req) begin
          if (w_vb_cond) begin
            w_swap = 1'b1;
          end else begin
            w_state_nxt = SWAP_PENDING;
          end
        end
      end
      SWAP_PENDING: begin
        if (w_vb_cond) begin
          w_swap      = 1'b1;
          w_state_nxt = SWAP_IDLE;
        end
      end
      default: w_state_nxt = SWAP_IDLE;
    endcase
  end

  // Bank 1 lives above bank 0; display reads the front bank, host writes the back bank
  assign w_rd_addr  = r_front_bank ? RAM_AW'(w_rd_off) + RAM_AW'(BANK_SIZE) : RAM_AW'(w_rd_off);
  assign w_wr_addr  = r_front_bank ? RAM_AW'(w_wr_off) : RAM_AW'(w_wr_off) + RAM_AW'(BANK_SIZE);
  assign front_bank = r_front_bank;
  assign swap_ack   = r_swap_ack;
`else
  logic w_unused_swap;

  assign w_unused_swap = swap_req;
  assign w_rd_addr     = RAM_AW'(w_rd_off);
  assign w_wr_addr     = RAM_AW'(w_wr_off);
  assign front_bank    = 1'b0;
  assign swap_ack      = 1'b0;
`endif

  vga_fb_ram #(
    .DEPTH  (RAM_DEPTH),
    .ADDR_W (RAM_AW),
    .DATA_W (8)
  ) u_ram (
    .i_clk     (vgaclk),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_active && !rst),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_pix)
  );

  assign wr_ready     = r_wr_ready;
  assign vblank_start = r_vblank;
  assign pix_red      = w_pix.r;
  assign pix_green    = w_pix.g;
  assign pix_blue     = w_pix.b;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: directed steps plus a randomized phase, all checked against a
// frame-level reference model. Honours VGA_FB_DOUBLE_BUFFER_EN like the design.
`timescale 1ns/1ps
module tb_vga_fb_reader;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       vgaclk   = 1'b0;
  logic       rst      = 1'b1;
  logic [9:0] hc_in    = '0;
  logic [9:0] vc_in    = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_x     = '0;
  logic [6:0] wr_y     = '0;
  logic [7:0] wr_data  = '0;
  logic       swap_req = 1'b0;
  logic       wr_ready;
  logic       swap_ack;
  logic       front_bank;
  logic       vblank_start;
  logic [2:0] pix_red;
  logic [2:0] pix_green;
  logic [1:0] pix_blue;

  always #20 vgaclk = ~vgaclk;

  vga_fb_reader dut (
    .vgaclk       (vgaclk),
    .rst          (rst),
    .hc_in        (hc_in),
    .vc_in        (vc_in),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .front_bank   (front_bank),
    .vblank_start (vblank_start),
    .pix_red      (pix_red),
    .pix_green    (pix_green),
    .pix_blue     (pix_blue)
  );

  // Reference model: stored image per bank, which entries are defined, and output expectations
  logic [7:0] fb    [2][120][160];
  bit         known [2][120][160];
  bit         m_ready, m_front, m_pend, m_ack, m_vb, m_pix_known;
  logic [7:0] m_pix;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model and the DUT, then compare every output
  task automatic step();
    int t, nh, nv, b;
    if (rst) begin
      m_pix = '0; m_pix_known = 1'b1; m_ready = 1'b0; m_front = 1'b0;
      m_pend = 1'b0; m_ack = 1'b0; m_vb = 1'b0;
    end else begin
      t  = (int'(vc_in) * 800 + int'(hc_in) + 1) % (800 * 525);
      nh = t % 800;
      nv = t / 800;
      if (nh < 640 && nv < 480) begin
        m_pix       = fb[m_front][nv / 4][nh / 4];
        m_pix_known = known[m_front][nv / 4][nh / 4];
      end else begin
        m_pix = '0; m_pix_known = 1'b1;
      end
      b = (DB && !m_front) ? 1 : 0;
      if (wr_valid && m_ready && int'(wr_x) < 160 && int'(wr_y) < 120) begin
        fb[b][wr_y][wr_x]    = wr_data;
        known[b][wr_y][wr_x] = 1'b1;
      end
      m_ready = 1'b1;
      m_vb    = (hc_in == 10'd0) && (vc_in == 10'd480);
      m_ack   = 1'b0;
      if (DB) begin
        if (m_vb && (swap_req || m_pend)) begin
          m_front = !m_front; m_ack = 1'b1; m_pend = 1'b0;
        end else if (swap_req) begin
          m_pend = 1'b1;
        end
      end
    end
    @(posedge vgaclk);
    #1;
    check("wr_ready", 32'(wr_ready), 32'(m_ready));
    check("swap_ack", 32'(swap_ack), 32'(m_ack));
    check("front_bank", 32'(front_bank), 32'(m_front));
    check("vblank_start", 32'(vblank_start), 32'(m_vb));
    if (m_pix_known) check("pix", 32'({pix_red, pix_green, pix_blue}), 32'(m_pix));
  endtask

  task automatic set_pos(input int h, input int v);
    hc_in = 10'(h);
    vc_in = 10'(v);
  endtask

  task automatic write_px(input int x, input int y, input logic [7:0] d);
    wr_valid = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_swap();
    set_pos(700, 100); swap_req = 1'b1; step();
    swap_req = 1'b0;
    set_pos(0, 480); step();
    set_pos(1, 480); step();
  endtask

  // Same value into both banks so the pixel shows regardless of which bank is in front
  task automatic write_both(input int x, input int y, input logic [7:0] d);
    set_pos(700, 0);
    write_px(x, y, d);
    do_swap();
    set_pos(700, 0);
    write_px(x, y, d);
  endtask

  task automatic pix_is(input string tag, input int h, input int v, input logic [7:0] exp);
    set_pos(h, v);
    step();
    check(tag, 32'({pix_red, pix_green, pix_blue}), 32'(exp));
  endtask

  initial begin
    bit f0;
    int r;

    // Reset state
    rst = 1'b1;
    repeat (5) step();
    check("rst_pix", 32'({pix_red, pix_green, pix_blue}), 32'(0));
    check("rst_wr_ready", 32'(wr_ready), 32'(0));
    check("rst_swap_ack", 32'(swap_ack), 32'(0));
    check("rst_front", 32'(front_bank), 32'(0));
    rst = 1'b0;
    set_pos(700, 0);
    step();
    check("wr_ready_after_rst", 32'(wr_ready), 32'(1));

    // Clear the top-left corner of both banks
    for (int y = 0; y < 4; y++) for (int x = 0; x < 6; x++) write_px(x, y, 8'h00);
    do_swap();
    set_pos(700, 0);
    for (int y = 0; y < 4; y++) for (int x = 0; x < 6; x++) write_px(x, y, 8'h00);

    // One stored pixel covers a 4x4 screen block
    write_both(3, 2, 8'hE3);
    for (int v = 7; v <= 12; v++) for (int h = 10; h <= 16; h++) begin
      set_pos(h, v); step();
    end
    pix_is("px_12_8", 11, 8, 8'hE3);
    pix_is("px_15_11", 14, 11, 8'hE3);
    pix_is("px_16_11", 15, 11, 8'h00);
    pix_is("px_12_12", 11, 12, 8'h00);
    pix_is("px_11_8", 10, 8, 8'h00);

    // Blanking and frame wrap
    pix_is("hblank_640", 639, 8, 8'h00);
    pix_is("hblank_701", 700, 8, 8'h00);
    pix_is("hblank_799", 798, 8, 8'h00);
    write_both(0, 0, 8'hFF);
    pix_is("wrap_0_0", 799, 524, 8'hFF);
    pix_is("vblank_row", 799, 479, 8'h00);

    // Out-of-range writes are accepted but dropped
    set_pos(700, 0);
    write_px(160, 0, 8'hFF);
    check("oor_ready_x", 32'(wr_ready), 32'(1));
    write_px(0, 120, 8'hFF);
    check("oor_ready_y", 32'(wr_ready), 32'(1));
    write_px(200, 127, 8'hFF);
    pix_is("oor_alias_0_1", 0, 4, 8'h00);
    do_swap();
    pix_is("oor_alias_0_1_swp", 0, 4, 8'h00);
    pix_is("oor_0_0_swp", 799, 524, 8'hFF);
    do_swap();
    pix_is("oor_0_0_swp2", 799, 524, 8'hFF);

    // Back-bank write becomes visible only after the vblank swap
    set_pos(700, 0);
    write_px(5, 1, 8'h1C);
    pix_is("pre_swap", 19, 4, DB ? 8'h00 : 8'h1C);
    f0 = m_front;
    set_pos(300, 100); swap_req = 1'b1; step();
    swap_req = 1'b0;
    check("ack_early", 32'(swap_ack), 32'(0));
    for (int v = 101; v < 105; v++) begin set_pos(0, v); step(); end
    set_pos(0, 480); step();
    check("ack_at_vblank", 32'(swap_ack), 32'(DB));
    check("front_toggled", 32'(front_bank), 32'(DB ? !f0 : 1'b0));
    check("vblank_pulse", 32'(vblank_start), 32'(1));
    set_pos(1, 480); step();
    check("ack_one_cycle", 32'(swap_ack), 32'(0));
    check("vblank_one_cycle", 32'(vblank_start), 32'(0));
    pix_is("post_swap", 19, 4, 8'h1C);

    // Requests while pending merge; request on the vblank edge swaps immediately
    set_pos(300, 100); swap_req = 1'b1; step();
    set_pos(300, 101); step();
    swap_req = 1'b0;
    set_pos(0, 480); step();
    check("ack_merged", 32'(swap_ack), 32'(DB));
    set_pos(1, 480); step();
    set_pos(0, 480); step();
    check("ack_no_second", 32'(swap_ack), 32'(0));
    swap_req = 1'b1; step();
    swap_req = 1'b0;
    check("ack_same_edge", 32'(swap_ack), 32'(DB));

    // Mid-frame reset keeps RAM contents
    set_pos(100, 200); step();
    rst = 1'b1;
    pix_is("rst_mid_pix", 11, 8, 8'h00);
    step();
    rst = 1'b0;
    set_pos(700, 0); step();
    pix_is("after_rst_px", 11, 8, 8'hE3);

    // Same-edge read and write of one location returns the old value
    wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd2; wr_data = 8'h55;
    pix_is("rw_same_edge", 11, 8, 8'hE3);
    wr_valid = 1'b0;
    pix_is("rw_next", 11, 8, DB ? 8'hE3 : 8'h55);

    // Randomized traffic around the written corner, frame edges and vblank
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      set_pos(int'($urandom_range(0, 40)), int'($urandom_range(0, 30)));
      else if (r < 7) set_pos(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      else if (r < 8) set_pos(799, int'($urandom_range(0, 524)));
      else            set_pos(0, 480);
      wr_valid = 1'($urandom_range(0, 1));
      wr_x     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 11));
      wr_y     = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 8));
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
